// File: rtl/tmul_pkg.sv
// Shared types and limits for the tile multiply-accumulate scheduler, FMA row array and Booth table.
package tmul_pkg;

    localparam int ROWS_MAX = 16;
    localparam int KMAX     = 16;

    typedef enum logic [1:0] {
        FP16 = 2'd0,
        BF16 = 2'd1,
        INT8 = 2'd2,
        RSVD = 2'd3
    } tmul_mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic       last;
    } wb_tag_t;

endpackage

// File: rtl/tmul_inflight_tracker.sv
// Delay line that follows each accepted FMA issue through the datapath to its accumulator writeback.
module tmul_inflight_tracker
    import tmul_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  wb_tag_t tag_in,
    output wb_tag_t tag_out,
    output logic    any_valid
);

    wb_tag_t [PIPE_LAT-1:0] tag_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int s = 1; s < PIPE_LAT; s++)
                tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign tag_out = tag_pipe[PIPE_LAT-1];

    // Ignores the stage being written back this cycle, so the scheduler can finish right behind it.
    always_comb begin
        any_valid = 1'b0;
        for (int s = 0; s < PIPE_LAT - 1; s++)
            any_valid = any_valid | tag_pipe[s].valid;
    end

endmodule

// File: rtl/tmul_fma_row_scheduler.sv
// Sequences C[M x 16] += A[M x K] * B[K x 16] on the FMA row array, k outer / i inner, one Booth table load per B row.
module tmul_fma_row_scheduler #(
    parameter int ROWS     = tmul_pkg::ROWS_MAX,
    parameter int KMAX     = tmul_pkg::KMAX,
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [4:0] m_cfg,
    input  logic [4:0] k_cfg,
    output logic       busy,
    output logic       done,
    output logic       cfg_err,
    output logic       lut_load,
    output logic [3:0] lut_b_row,
    output logic [1:0] lut_mode,
    output logic       iss_valid,
    input  logic       iss_ready,
    output logic [3:0] iss_a_row,
    output logic [3:0] iss_k,
    output logic       iss_first,
    output logic       wb_valid,
    output logic [3:0] wb_a_row,
    output logic       wb_last
);
    import tmul_pkg::*;

    sched_state_e state;
    logic [4:0]   m_q, k_q, i_q, kk_q;
    logic [4:0]   i_nxt, k_nxt;
    logic         cfg_ok;
    logic         pending;
    wb_tag_t      tag_in, tag_out;

    assign cfg_ok = (mode != RSVD)
                 && (m_cfg != 5'd0) && (int'(m_cfg) <= ROWS)
                 && (k_cfg != 5'd0) && (int'(k_cfg) <= KMAX);

    assign i_nxt = i_q + 5'd1;
    assign k_nxt = kk_q + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m_q       <= '0;
            k_q       <= '0;
            i_q       <= '0;
            kk_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            lut_load  <= 1'b0;
            lut_b_row <= '0;
            lut_mode  <= '0;
            iss_valid <= 1'b0;
            iss_a_row <= '0;
            iss_k     <= '0;
            iss_first <= 1'b0;
        end else begin
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            lut_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            m_q       <= m_cfg;
                            k_q       <= k_cfg;
                            i_q       <= '0;
                            kk_q      <= '0;
                            busy      <= 1'b1;
                            lut_load  <= 1'b1;
                            lut_b_row <= '0;
                            lut_mode  <= mode;
                            state     <= LOAD;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    iss_valid <= 1'b1;
                    iss_a_row <= i_q[3:0];
                    iss_k     <= kk_q[3:0];
                    iss_first <= (kk_q == 5'd0);
                    state     <= ISSUE;
                end
                ISSUE: begin
                    // Everything holds while the datapath stalls us.
                    if (iss_ready) begin
                        if (i_q < m_q - 5'd1) begin
                            i_q       <= i_nxt;
                            iss_a_row <= i_nxt[3:0];
                        end else begin
                            iss_valid <= 1'b0;
                            iss_a_row <= '0;
                            iss_k     <= '0;
                            iss_first <= 1'b0;
                            if (kk_q < k_q - 5'd1) begin
                                i_q       <= '0;
                                kk_q      <= k_nxt;
                                lut_load  <= 1'b1;
                                lut_b_row <= k_nxt[3:0];
                                state     <= LOAD;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = iss_valid & iss_ready;
        tag_in.row   = iss_a_row;
        tag_in.last  = (kk_q == k_q - 5'd1);
    end

    tmul_inflight_tracker #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (pending)
    );

    assign wb_valid = tag_out.valid;
    assign wb_a_row = tag_out.row;
    assign wb_last  = tag_out.last;

endmodule

// File: doc/tmul_fma_row_scheduler.md
Name: tmul_fma_row_scheduler

Overview:
- Sequences one tile multiply-accumulate C[M×16] += A[M×K] · B[K×16] on the 16-lane FMA row array.
- The 16 lanes share one radix-8 Booth lookup table built from a B row.
- Loop order is k outer, i inner, so each B row is loaded once and reused across all M rows of A.
- Issues operand addresses under a valid/ready handshake, tracks in-flight FMAs through the datapath pipeline, drains, and signals completion to the tile front end.

Parameters:
- ROWS, 16, maximum M (rows of A/C).
- KMAX, 16, maximum K (rows of B).
- PIPE_LAT, 3, cycles from accepted issue to accumulator writeback (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start a tile op; sampled only in IDLE
- mode  in  2  0=FP16, 1=BF16, 2=INT8, 3=reserved
- m_cfg  in  5  number of A rows, 1..ROWS
- k_cfg  in  5  number of B rows, 1..KMAX
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at completion
- cfg_err  out  1  one-cycle pulse when start is rejected
- lut_load  out  1  load the Booth table from B row lut_b_row
- lut_b_row  out  4  B row index
- lut_mode  out  2  latched mode to the table and multiplexer
- iss_valid  out  1  an operand issue is pending
- iss_ready  in  1  datapath accepts the issue
- iss_a_row  out  4  A row i
- iss_k  out  4  k index; selects the A[i][k] element
- iss_first  out  1  k==0: lanes overwrite instead of accumulate
- wb_valid  out  1  writeback of an accepted issue, PIPE_LAT cycles later
- wb_a_row  out  4  row index of that writeback
- wb_last  out  1  writeback belongs to k==k_cfg-1, so the C row is final

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters and the pipeline tracker cleared.
- Reset mid-operation abandons the op immediately. There is no partial done and no writebacks afterwards.
- IDLE:
  - start with a legal config (mode≠3, 1≤m_cfg≤ROWS, 1≤k_cfg≤KMAX): latch mode, m, k; i=0, k=0; go to LOAD.
  - start with an illegal config: pulse cfg_err the next cycle and stay in IDLE.
  - start while busy is ignored.
- LOAD (exactly 1 cycle): lut_load=1, lut_b_row=k; go to ISSUE.
- ISSUE:
  - iss_valid=1 with iss_a_row=i, iss_k=k, iss_first=(k==0).
  - Outputs hold stable while iss_ready=0; stalls are unbounded.
  - On iss_valid&iss_ready:
    - if i<m-1: i++.
    - else if k<k-1 (latched k count): i=0, k++, go to LOAD.
    - else go to DRAIN.
  - iss_valid is never asserted in LOAD, DRAIN, or DONE.
- Pipeline tracker:
  - A PIPE_LAT-deep shift register of {valid,row,last}, shifted every cycle regardless of state.
  - An accepted issue at cycle t gives wb_valid=1 at cycle t+PIPE_LAT with the matching row and last.
- DRAIN: stays until the tracker holds no valid entry, then goes to DONE. done therefore follows the final wb_valid by one cycle.
- DONE (1 cycle): done=1, busy=0; go to IDLE. A start arriving in the DONE cycle is ignored.
- Unstalled latency from the start cycle to the done cycle: k·(m+1) + PIPE_LAT + 1.
- Counters are 5 bits internally. Index outputs are truncated to 4 bits; legal configs never exceed 15.

Decomposition:
- Package tmul_pkg holds:
  - typedef tmul_mode_e {FP16, BF16, INT8, RSVD}
  - typedef sched_state_e {IDLE, LOAD, ISSUE, DRAIN, DONE}
  - struct wb_tag_t {valid, row[3:0], last}
  - constants ROWS_MAX=16 and KMAX=16, shared with the FMA row array and the Booth table.
- One natural sub-module: tmul_inflight_tracker, the PIPE_LAT shift register of wb_tag_t with an any_valid output.

Test Plan:
- m=2, k=2, FP16, iss_ready=1, PIPE_LAT=3, start at cycle 0:
  - lut_load at cycles 1 and 4.
  - Issues at 2,3,5,6 with (i,k) = (0,0), (1,0), (0,1), (1,1); iss_first at 2 and 3.
  - wb_valid at 5,6,8,9; wb_last at 8 and 9.
  - done at cycle 10.
- m=16, k=16, INT8, iss_ready pseudo-random at 50%:
  - exactly 256 accepted issues and 256 writebacks, in (k,i) raster order.
  - outputs stable during every stall; done follows the last writeback by 1 cycle.
- Illegal configs (mode=3; m_cfg=0; k_cfg=17): cfg_err pulses once, busy stays 0, no lut_load or iss_valid.
- start pulsed during ISSUE and during DONE: ignored, and the first op completes with the unchanged count.
- rst_n dropped in ISSUE with 2 writebacks in flight: all outputs 0 asynchronously, no wb_valid or done after release, and a new start runs cleanly.
- m=1, k=1, BF16: lut_load at 1, single issue at 2 with iss_first=1, wb_valid and wb_last at 5, done at 6.
